// File: rtl/function_sweep_checker_pkg.sv
// function_sweep_checker_pkg: FSM state encodings, timer width and parameter range check
package function_sweep_checker_pkg;
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WAIT   = 2'd1;
  localparam logic [1:0] S_SAMPLE = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;
  localparam int TIMER_W = 8;
  function automatic bit params_ok(input int n, input int settle);
    return n >= 1 && n <= 8 && settle >= 1 && settle <= 255;
  endfunction
endpackage

// File: rtl/function_sweep_checker_if.sv
// function_sweep_checker_if: sweep control, stimulus/response and result bundle
// master = lab wrapper side (drives start, golden, f_dut); slave = the checker
interface function_sweep_checker_if #(parameter int N = 3) ();
  localparam int W = 1 << N;
  logic start;
  logic [W-1:0] golden;
  logic [N-1:0] stim;
  logic f_dut;
  logic busy;
  logic done;
  logic pass;
  logic [N:0] err_cnt;
  logic [N-1:0] first_err;
  logic first_err_vld;
  logic [W-1:0] resp;
  modport master (
    output start, golden, f_dut,
    input  stim, busy, done, pass, err_cnt, first_err, first_err_vld, resp
  );
  modport slave (
    input  start, golden, f_dut,
    output stim, busy, done, pass, err_cnt, first_err, first_err_vld, resp
  );
endinterface

// File: rtl/function_sweep_checker_settle_timer.sv
// function_sweep_checker_settle_timer: loadable down-counter with zero flag
// ports: clk, reset (async high), load/load_val reload, dec decrements, zero when count is 0
module function_sweep_checker_settle_timer #(parameter int W = 8) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (dec) cnt <= cnt - 1'b1;
  assign zero = cnt == '0;
endmodule

// File: rtl/function_sweep_checker.sv
// function_sweep_checker: exhaustive truth-table sweep of an N-input function against a golden table
// ports: clk, reset (async high), bus (slave): start/golden/f_dut in; stim, busy, done, pass,
//        err_cnt, first_err, first_err_vld, resp out
module function_sweep_checker #(
  parameter int N = 3,
  parameter int SETTLE_CYC = 1
) (
  input logic clk,
  input logic reset,
  function_sweep_checker_if.slave bus
);
  import function_sweep_checker_pkg::*;
  localparam int W = 1 << N;
  if (!params_ok(N, SETTLE_CYC)) begin : g_bad_params
    $error("function_sweep_checker: N must be 1..8 and SETTLE_CYC 1..255");
  end
  logic [1:0] state;
  logic [W-1:0] golden_q, resp;
  logic [N-1:0] stim, first_err;
  logic [N:0] err_cnt;
  logic first_err_vld, go, last, zero;
  assign go = bus.start && (state == S_IDLE || state == S_DONE);
  assign last = stim == '1;
  function_sweep_checker_settle_timer #(.W(TIMER_W)) u_timer (
    .clk,
    .reset,
    .load(go || (state == S_SAMPLE && !last)),
    .load_val(TIMER_W'(SETTLE_CYC - 1)),
    .dec(state == S_WAIT && !zero),
    .zero
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= S_IDLE;
      golden_q <= '0;
      resp <= '0;
      stim <= '0;
      err_cnt <= '0;
      first_err <= '0;
      first_err_vld <= 1'b0;
    end else if (go) begin
      state <= S_WAIT;
      golden_q <= bus.golden;
      resp <= '0;
      stim <= '0;
      err_cnt <= '0;
      first_err <= '0;
      first_err_vld <= 1'b0;
    end else if (state == S_WAIT) begin
      if (zero) state <= S_SAMPLE;
    end else if (state == S_SAMPLE) begin
      resp[stim] <= bus.f_dut;
      if (bus.f_dut != golden_q[stim]) begin
        err_cnt <= err_cnt + 1'b1;
        if (!first_err_vld) begin
          first_err <= stim;
          first_err_vld <= 1'b1;
        end
      end
      if (last) state <= S_DONE;
      else begin
        stim <= stim + 1'b1;
        state <= S_WAIT;
      end
    end
  assign bus.stim = stim;
  assign bus.busy = state == S_WAIT || state == S_SAMPLE;
  assign bus.done = state == S_DONE;
  assign bus.pass = state == S_DONE && err_cnt == '0;
  assign bus.err_cnt = err_cnt;
  assign bus.first_err = first_err;
  assign bus.first_err_vld = first_err_vld;
  assign bus.resp = resp;
endmodule
